// File: rtl/bp_pkg.sv
// Shared types and constants for the IF-stage branch predictor / BTB.
package bp_pkg;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned MAX_TAG_W = 8;  // TAG_W for the smallest legal table (4 entries)

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Tag is stored zero-extended so one entry type serves every table size.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [PC_W-1:0]      target;
    ctr_t                 ctr;
  } btb_entry_t;

  function automatic int unsigned idxW(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tagW(input int unsigned entries);
    return (PC_W - 2) - $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX-stage resolution bus between the pipeline and the predictor.
interface branch_predictor_if;
  import bp_pkg::*;

  logic [PC_W-1:0] IF_PC;
  logic            PRED_TAKEN;
  logic [PC_W-1:0] PRED_TARGET;
  logic            BTB_HIT;
  logic            UPD_VALID;
  logic [PC_W-1:0] UPD_PC;
  logic            UPD_TAKEN;
  logic [PC_W-1:0] UPD_TARGET;

  modport master (
    output IF_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET,
    input  PRED_TAKEN, PRED_TARGET, BTB_HIT
  );

  modport slave (
    input  IF_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET,
    output PRED_TAKEN, PRED_TARGET, BTB_HIT
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT: ctr_next = taken ? WNT : SNT;
      WNT: ctr_next = taken ? WT  : SNT;
      WT:  ctr_next = taken ? ST  : WNT;
      ST:  ctr_next = taken ? ST  : WT;
      default: ctr_next = CTR_RESET;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup on IF_PC,
// trained by resolved branches from EX. Lookups see pre-update contents.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input logic              CLK,
  input logic              RSTn,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = idxW(ENTRIES);
  localparam int unsigned TAG_W = tagW(ENTRIES);
  localparam int unsigned TAG_LO = 2 + IDX_W;

  btb_entry_t btb [ENTRIES];

  logic [IDX_W-1:0]     lkIdx;
  logic [MAX_TAG_W-1:0] lkTag;
  btb_entry_t           lkEntry;
  logic                 lkHit;
  logic                 lkTaken;
  logic [PC_W-1:0]      lkTarget;

  logic [IDX_W-1:0]     updIdx;
  logic [MAX_TAG_W-1:0] updTag;
  btb_entry_t           updEntry;
  logic                 updHit;
  ctr_t                 ctrNext;

  logic unusedBits;
  assign unusedBits = ^{bus.IF_PC[1:0], bus.UPD_PC[1:0]};

  // Lookup path
  always_comb begin
    lkIdx    = bus.IF_PC[TAG_LO-1:2];
    lkTag    = MAX_TAG_W'(bus.IF_PC[PC_W-1:TAG_LO]);
    lkEntry  = btb[lkIdx];
    lkHit    = lkEntry.valid && (lkEntry.tag == lkTag);
    lkTaken  = lkHit && lkEntry.ctr[1];
    lkTarget = lkTaken ? lkEntry.target : PC_W'(bus.IF_PC + PC_W'(4));
  end

  assign bus.BTB_HIT     = lkHit;
  assign bus.PRED_TAKEN  = lkTaken;
  assign bus.PRED_TARGET = lkTarget;

  // Update path
  always_comb begin
    updIdx   = bus.UPD_PC[TAG_LO-1:2];
    updTag   = MAX_TAG_W'(bus.UPD_PC[PC_W-1:TAG_LO]);
    updEntry = btb[updIdx];
    updHit   = updEntry.valid && (updEntry.tag == updTag);
  end

  bp_sat_ctr2 u_sat_ctr (
    .ctr      (updEntry.ctr),
    .taken    (bus.UPD_TAKEN),
    .ctr_next (ctrNext)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= CTR_RESET;
      end
    end else if (bus.UPD_VALID) begin
      if (updHit) begin
        btb[updIdx].ctr <= ctrNext;
        if (bus.UPD_TAKEN) btb[updIdx].target <= bus.UPD_TARGET;
      end else if (bus.UPD_TAKEN) begin
        // Miss-taken evicts whatever occupies the slot
        btb[updIdx].valid  <= 1'b1;
        btb[updIdx].tag    <= updTag;
        btb[updIdx].target <= bus.UPD_TARGET;
        btb[updIdx].ctr    <= WT;
      end
    end
  end

  if (TAG_W > MAX_TAG_W || ENTRIES < 4 || ENTRIES > 256) begin : gBadParam
    $error("branch_predictor: ENTRIES out of range");
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table plus collision and async-reset sequences.
module tb_branch_predictor;

  logic CLK;
  logic RSTn;
  int   checks;
  int   failures;

  branch_predictor_if bus ();

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        doUpd;
    logic [11:0] updPc;
    logic        updTaken;
    logic [11:0] updTarget;
    logic [11:0] lkPc;
    logic        expHit;
    logic        expTaken;
    logic [11:0] expTarget;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic doUpd, input logic [11:0] updPc, input logic updTaken,
                              input logic [11:0] updTarget, input logic [11:0] lkPc,
                              input logic expHit, input logic expTaken, input logic [11:0] expTarget);
    vec_t v;
    v.doUpd = doUpd; v.updPc = updPc; v.updTaken = updTaken; v.updTarget = updTarget;
    v.lkPc = lkPc; v.expHit = expHit; v.expTaken = expTaken; v.expTarget = expTarget;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, got, exp);
    end
  endtask

  task automatic checkLookup(input string name, input logic hit, input logic tk, input logic [11:0] tgt);
    check({name, ".hit"},    12'(bus.BTB_HIT),    12'(hit));
    check({name, ".taken"},  12'(bus.PRED_TAKEN), 12'(tk));
    check({name, ".target"}, bus.PRED_TARGET,     tgt);
  endtask

  task automatic doUpdate(input logic [11:0] pc, input logic tk, input logic [11:0] tgt);
    @(negedge CLK);
    bus.UPD_VALID  = 1'b1;
    bus.UPD_PC     = pc;
    bus.UPD_TAKEN  = tk;
    bus.UPD_TARGET = tgt;
    @(posedge CLK);
    #1;
    bus.UPD_VALID  = 1'b0;
  endtask

  task automatic lookup(input logic [11:0] pc);
    bus.IF_PC = pc;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTn           = 1'b0;
    bus.IF_PC      = 12'h010;
    bus.UPD_VALID  = 1'b0;
    bus.UPD_PC     = '0;
    bus.UPD_TAKEN  = 1'b0;
    bus.UPD_TARGET = '0;

    // Counter walk follows the encoding: WT -NT-> WNT -NT-> SNT, then up again.
    vecs[0]  = mk(0, 12'h000, 0, 12'h000, 12'h010, 0, 0, 12'h014);
    vecs[1]  = mk(0, 12'h000, 0, 12'h000, 12'hFFC, 0, 0, 12'h000);
    vecs[2]  = mk(1, 12'h020, 1, 12'h040, 12'h020, 1, 1, 12'h040);
    vecs[3]  = mk(1, 12'h020, 0, 12'h000, 12'h020, 1, 0, 12'h024);
    vecs[4]  = mk(1, 12'h020, 0, 12'h000, 12'h020, 1, 0, 12'h024);
    vecs[5]  = mk(1, 12'h020, 0, 12'h000, 12'h020, 1, 0, 12'h024);
    vecs[6]  = mk(1, 12'h020, 1, 12'h040, 12'h020, 1, 0, 12'h024);
    vecs[7]  = mk(1, 12'h020, 1, 12'h040, 12'h020, 1, 1, 12'h040);
    vecs[8]  = mk(1, 12'h020, 1, 12'h040, 12'h020, 1, 1, 12'h040);
    vecs[9]  = mk(1, 12'h020, 1, 12'h060, 12'h020, 1, 1, 12'h060);
    vecs[10] = mk(1, 12'h020, 0, 12'h000, 12'h020, 1, 1, 12'h060);
    vecs[11] = mk(1, 12'h100, 0, 12'h000, 12'h100, 0, 0, 12'h104);
    vecs[12] = mk(1, 12'h100, 1, 12'h200, 12'h100, 1, 1, 12'h200);
    vecs[13] = mk(1, 12'h500, 1, 12'h080, 12'h100, 0, 0, 12'h104);
    vecs[14] = mk(0, 12'h000, 0, 12'h000, 12'h500, 1, 1, 12'h080);
    vecs[15] = mk(0, 12'h000, 0, 12'h000, 12'h020, 1, 1, 12'h060);
    vecs[16] = mk(1, 12'h500, 0, 12'h000, 12'h500, 1, 0, 12'h504);

    #12;
    checkLookup("in_reset", 1'b0, 1'b0, 12'h014);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].doUpd) doUpdate(vecs[i].updPc, vecs[i].updTaken, vecs[i].updTarget);
      lookup(vecs[i].lkPc);
      checkLookup($sformatf("vec%0d", i), vecs[i].expHit, vecs[i].expTaken, vecs[i].expTarget);
    end

    // Same-cycle lookup and allocation to the same slot: old contents seen first
    @(negedge CLK);
    bus.IF_PC      = 12'h030;
    bus.UPD_VALID  = 1'b1;
    bus.UPD_PC     = 12'h030;
    bus.UPD_TAKEN  = 1'b1;
    bus.UPD_TARGET = 12'h0A0;
    #1;
    checkLookup("collide_pre", 1'b0, 1'b0, 12'h034);
    @(posedge CLK);
    #1;
    bus.UPD_VALID = 1'b0;
    checkLookup("collide_post", 1'b1, 1'b1, 12'h0A0);

    // Fill every index, then assert reset between edges with an update pending
    for (int i = 0; i < 16; i++) doUpdate(12'(i * 4), 1'b1, 12'(12'h300 + i * 4));
    lookup(12'h008);
    checkLookup("filled", 1'b1, 1'b1, 12'h308);
    @(negedge CLK);
    bus.UPD_VALID  = 1'b1;
    bus.UPD_PC     = 12'h008;
    bus.UPD_TAKEN  = 1'b1;
    bus.UPD_TARGET = 12'h777;
    #2;
    RSTn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lookup(12'(i * 4));
      check($sformatf("rst_hit%0d", i), 12'(bus.BTB_HIT), 12'h000);
    end
    bus.UPD_VALID = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    lookup(12'h008);
    checkLookup("after_rst", 1'b0, 1'b0, 12'h00C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
